// File: rtl/fir_sched_if.sv
// rtl/fir_sched_if.sv - sample, FIR and result handshake bundle for fir_sched
interface fir_sched_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             flush_i;
  logic             fir_en_o;
  logic [WIDTH-1:0] fir_data_o;
  logic [WIDTH-1:0] fir_result_i;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
  logic             busy_o;

  // Controller side
  modport slave (
    input  in_valid_i, in_data_i, flush_i, fir_result_i, out_ready_i,
    output in_ready_o, fir_en_o, fir_data_o, out_valid_o, out_data_o, busy_o
  );

  // Sample source / result sink / FIR side
  modport master (
    output in_valid_i, in_data_i, flush_i, fir_result_i, out_ready_i,
    input  in_ready_o, fir_en_o, fir_data_o, out_valid_o, out_data_o, busy_o
  );
endinterface

// File: rtl/fir_sched.sv
// rtl/fir_sched.sv - enable sequencer, decimator and output register for the pipelined FIR
module fir_sched #(
  parameter int WIDTH = 16,
  parameter int LAT   = 3,
  parameter int DECIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  fir_sched_if.slave  bus
);
  localparam int CW = 4;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    fill_cnt;
  logic [CW-1:0]    dec_cnt;
  logic [CW-1:0]    flush_cnt;
  logic             cap_pend;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             stall;
  logic             in_ready;
  logic             fir_en;
  logic [WIDTH-1:0] fir_data;
  logic             result_bearing;
  logic             flush_done;

  // Handshake, enable strobe and next state; everything is gated off while rst is high
  always_comb begin
    state_nx       = state;
    fir_en         = 1'b0;
    fir_data       = '0;
    flush_done     = 1'b0;
    stall          = (out_valid_q & ~bus.out_ready_i) | cap_pend;
    in_ready       = ~rst & (state == RUN) & ~bus.flush_i & ~stall;
    case (state)
      RUN: begin
        fir_en   = bus.in_valid_i & in_ready;
        fir_data = rst ? '0 : bus.in_data_i;
        if (bus.flush_i && !rst)
          state_nx = FLUSH;
      end
      FLUSH: begin
        fir_en     = ~stall & ~rst;
        flush_done = fir_en & (flush_cnt == CW'(LAT - 2));
        if (flush_done)
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    result_bearing = fir_en & (fill_cnt == CW'(LAT - 1));
  end

  // State, fill/decimation/flush counters and the capture request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fill_cnt  <= '0;
      dec_cnt   <= '0;
      flush_cnt <= '0;
      cap_pend  <= 1'b0;
    end else begin
      state    <= state_nx;
      cap_pend <= result_bearing & (dec_cnt == '0);
      if (flush_done) begin
        fill_cnt  <= '0;
        dec_cnt   <= '0;
        flush_cnt <= '0;
      end else begin
        if (fir_en && fill_cnt != CW'(LAT - 1))
          fill_cnt <= fill_cnt + 1'b1;
        if (result_bearing)
          dec_cnt <= (dec_cnt == CW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
        if (state == FLUSH && fir_en)
          flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // One-entry output register; a capture always finds it free because of the stall term
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (cap_pend) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.fir_result_i;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.fir_en_o    = fir_en;
  assign bus.fir_data_o  = fir_data;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = ~rst & ((state == FLUSH) | cap_pend | out_valid_q);
endmodule

// File: tb/tb_fir_sched.sv
// tb/tb_fir_sched.sv - directed bench for fir_sched with a two-tap FIR stand-in
module tb_fir_sched;
  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        in_valid, flush, out_ready;
  logic [15:0] in_data;
  int          vec = 0;
  int          errs = 0;
  int          acc4 = 0;
  int          idx;
  logic        stl;
  logic [15:0] q4[$];
  logic signed [15:0] p1 [4];
  logic signed [15:0] p4 [4];

  always #5 clk = ~clk;

  fir_sched_if #(.WIDTH(16)) b1 ();
  fir_sched_if #(.WIDTH(16)) b4 ();

  fir_sched #(.WIDTH(16), .LAT(3), .DECIM(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  fir_sched #(.WIDTH(16), .LAT(3), .DECIM(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

  assign b1.in_valid_i  = in_valid;
  assign b1.in_data_i   = in_data;
  assign b1.flush_i     = flush;
  assign b1.out_ready_i = out_ready;
  assign b4.in_valid_i  = in_valid;
  assign b4.in_data_i   = in_data;
  assign b4.flush_i     = flush;
  assign b4.out_ready_i = out_ready;

  // FIR stand-in: h0 = 1 at delay 2, h1 = 0.5 at delay 3, advanced only by fir_en
  always_ff @(posedge clk) begin
    if (rst1) begin
      for (int i = 0; i < 4; i++) p1[i] <= '0;
    end else if (b1.fir_en_o) begin
      p1[0] <= b1.fir_data_o;
      for (int i = 1; i < 4; i++) p1[i] <= p1[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst4) begin
      for (int i = 0; i < 4; i++) p4[i] <= '0;
    end else if (b4.fir_en_o) begin
      p4[0] <= b4.fir_data_o;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
  end

  assign b1.fir_result_i = p1[2] + (p1[3] >>> 1);
  assign b4.fir_result_i = p4[2] + (p4[3] >>> 1);

  // Beat and result monitor for the DECIM=4 instance
  always @(posedge clk) begin
    if (!rst4 && b4.in_valid_i && b4.in_ready_o) acc4 <= acc4 + 1;
    if (!rst4 && b4.out_valid_o && out_ready) q4.push_back(b4.out_data_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r1, input logic r4, input logic v, input logic [15:0] d,
                      input logic f, input logic rdy);
    @(negedge clk);
    rst1 = r1; rst4 = r4; in_valid = v; in_data = d; flush = f; out_ready = rdy;
    #1;
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; in_valid = 1'b1; in_data = 16'd5; flush = 1'b0; out_ready = 1'b1;

    // Reset with in_valid held high
    for (int c = 0; c < 3; c++) begin
      step(1, 1, 1, 16'd5, 0, 1);
      chk("rst_outs1", {b1.in_ready_o, b1.fir_en_o, b1.out_valid_o, b1.busy_o,
                        b1.fir_data_o, b1.out_data_o}, 0);
      chk("rst_outs4", {b4.in_ready_o, b4.fir_en_o, b4.out_valid_o, b4.busy_o,
                        b4.fir_data_o, b4.out_data_o}, 0);
    end

    // DECIM=1 impulse response
    step(0, 1, 1, 16'd16384, 0, 1);
    chk("a0_in_ready", b1.in_ready_o, 1);
    chk("a0_fir_en", b1.fir_en_o, 1);
    chk("a0_fir_data", b1.fir_data_o, 16384);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a1_fir_en", b1.fir_en_o, 1);
    chk("a1_out_valid", b1.out_valid_o, 0);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a2_fir_en", b1.fir_en_o, 1);
    chk("a2_out_valid", b1.out_valid_o, 0);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a3_in_ready", b1.in_ready_o, 0);
    chk("a3_fir_en", b1.fir_en_o, 0);
    chk("a3_busy", b1.busy_o, 1);
    chk("a3_out_valid", b1.out_valid_o, 0);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a4_out_valid", b1.out_valid_o, 1);
    chk("a4_out_data", b1.out_data_o, 16384);
    chk("a4_in_ready", b1.in_ready_o, 1);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a5_in_ready", b1.in_ready_o, 0);
    chk("a5_out_valid", b1.out_valid_o, 0);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a6_out_valid", b1.out_valid_o, 1);
    chk("a6_out_data", b1.out_data_o, 8192);
    chk("a6_in_ready", b1.in_ready_o, 1);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a7_in_ready", b1.in_ready_o, 0);
    step(0, 1, 1, 16'd0, 0, 1);
    chk("a8_out_valid", b1.out_valid_o, 1);
    chk("a8_out_data", b1.out_data_o, 0);

    // DECIM=4, 18 back-to-back samples 100..117
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      stl = (c == 3) || (c == 8) || (c == 13) || (c == 18);
      step(1, 0, 1, 16'(100 + idx), 0, 1);
      chk("b_in_ready", b4.in_ready_o, !stl);
      chk("b_out_valid", b4.out_valid_o, (c == 4) || (c == 9) || (c == 14) || (c == 19));
      if (c == 4)  chk("b_out_data_e3",  b4.out_data_o, 100);
      if (c == 9)  chk("b_out_data_e7",  b4.out_data_o, 155);
      if (c == 14) chk("b_out_data_e11", b4.out_data_o, 161);
      if (c == 19) chk("b_out_data_e15", b4.out_data_o, 167);
      if (!stl) idx++;
    end
    step(1, 0, 0, 16'd0, 0, 1);
    chk("b_beats", acc4, 18);
    chk("b_outputs", q4.size(), 4);

    // Backpressure: out_ready low for 20 cycles, input continuously offered
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 1, (c == 0) ? 16'd118 : 16'd119, 0, 0);
      chk("c_in_ready", b4.in_ready_o, c == 0);
      chk("c_fir_en", b4.fir_en_o, c == 0);
      chk("c_out_valid", b4.out_valid_o, c >= 2);
      if (c >= 2) chk("c_out_hold", b4.out_data_o, 173);
    end
    step(1, 0, 1, 16'd119, 0, 1);
    chk("c_release_in_ready", b4.in_ready_o, 1);
    chk("c_release_fir_en", b4.fir_en_o, 1);
    chk("c_release_data", b4.out_data_o, 173);
    step(1, 0, 0, 16'd0, 0, 1);
    chk("c_drained", b4.out_valid_o, 0);
    chk("c_beats", acc4, 20);
    chk("c_outputs", q4.size(), 5);
    chk("c_out_once", q4[4], 173);

    // Flush after 10 samples 200..209
    step(1, 1, 0, 16'd0, 0, 1);
    step(1, 1, 0, 16'd0, 0, 1);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      stl = (c == 3) || (c == 8);
      step(1, 0, 1, 16'(200 + idx), 0, 1);
      chk("d_in_ready", b4.in_ready_o, !stl);
      if (c == 4) chk("d_out_e3", b4.out_data_o, 200);
      if (c == 9) chk("d_out_e7", b4.out_data_o, 305);
      if (!stl) idx++;
    end
    step(1, 0, 1, 16'd210, 1, 1);
    chk("d_flush_in_ready", b4.in_ready_o, 0);
    chk("d_flush_fir_en", b4.fir_en_o, 0);
    step(1, 0, 1, 16'd210, 0, 1);
    chk("d_z1_fir_en", b4.fir_en_o, 1);
    chk("d_z1_fir_data", b4.fir_data_o, 0);
    chk("d_z1_in_ready", b4.in_ready_o, 0);
    chk("d_z1_busy", b4.busy_o, 1);
    step(1, 0, 1, 16'd210, 0, 1);
    chk("d_stall_fir_en", b4.fir_en_o, 0);
    chk("d_stall_busy", b4.busy_o, 1);
    step(1, 0, 1, 16'd210, 0, 1);
    chk("d_z2_fir_en", b4.fir_en_o, 1);
    chk("d_z2_fir_data", b4.fir_data_o, 0);
    chk("d_z2_out_valid", b4.out_valid_o, 1);
    chk("d_z2_out_data", b4.out_data_o, 311);
    step(1, 0, 1, 16'd300, 0, 1);
    chk("d_n1_in_ready", b4.in_ready_o, 1);
    chk("d_n1_fir_en", b4.fir_en_o, 1);
    chk("d_n1_busy", b4.busy_o, 0);
    step(1, 0, 1, 16'd301, 0, 1);
    chk("d_n2_fir_en", b4.fir_en_o, 1);
    step(1, 0, 1, 16'd302, 0, 1);
    chk("d_n3_fir_en", b4.fir_en_o, 1);
    chk("d_n3_out_valid", b4.out_valid_o, 0);
    step(1, 0, 1, 16'd303, 0, 1);
    chk("d_n3_capture_stall", b4.in_ready_o, 0);
    step(1, 0, 0, 16'd0, 0, 1);
    chk("d_post_out_valid", b4.out_valid_o, 1);
    chk("d_post_out_data", b4.out_data_o, 300);

    // Reset after the first flush enable
    step(1, 0, 0, 16'd0, 0, 1);
    step(1, 0, 0, 16'd0, 1, 1);
    chk("e_flush_fir_en", b4.fir_en_o, 0);
    step(1, 0, 0, 16'd0, 0, 1);
    chk("e_z1_fir_en", b4.fir_en_o, 1);
    chk("e_z1_busy", b4.busy_o, 1);
    step(1, 1, 0, 16'd0, 0, 1);
    chk("e_rst_fir_en", b4.fir_en_o, 0);
    chk("e_rst_busy", b4.busy_o, 0);
    step(1, 0, 0, 16'd0, 0, 1);
    chk("e_after_fir_en", b4.fir_en_o, 0);
    chk("e_after_in_ready", b4.in_ready_o, 1);
    chk("e_after_busy", b4.busy_o, 0);
    chk("e_after_out_valid", b4.out_valid_o, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 1, 16'(400 + c), 0, 1);
      chk("e_fill_in_ready", b4.in_ready_o, 1);
      chk("e_fill_out_valid", b4.out_valid_o, 0);
    end
    step(1, 0, 1, 16'd403, 0, 1);
    chk("e_capture_stall", b4.in_ready_o, 0);
    step(1, 0, 0, 16'd0, 0, 1);
    chk("e_out_valid", b4.out_valid_o, 1);
    chk("e_out_data", b4.out_data_o, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/fir_sched.md
# fir_sched

Sequencing controller for the 17-tap pipelined FIR in the FM demodulator chain. It accepts merged baseband samples over a valid/ready handshake and issues the single enable strobe that advances every FIR pipeline stage. It tracks pipeline fill, decimates the FIR result stream and delivers it through a one-entry output register with backpressure. A flush command drains the pipeline with zero samples.

## Interface
- WIDTH, 16, sample and result width.
- LAT, 3, FIR enables between a sample entering the filter and its first contribution at `fir_result_i`. Legal range 2..8.
- DECIM, 4, decimation factor. Legal range 1..16.
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  input sample valid.
- in_data_i  in  WIDTH  signed input sample.
- in_ready_o  out  1  controller accepts `in_data_i` this cycle.
- flush_i  in  1  single-cycle pulse requesting a pipeline drain.
- fir_en_o  out  1  FIR enable; drives both FIR enable inputs (start and merge-finished).
- fir_data_o  out  WIDTH  sample to FIR `data_i`.
- fir_result_i  in  WIDTH  FIR `data_o`.
- out_valid_o  out  1  decimated result valid.
- out_data_o  out  WIDTH  decimated result, signed.
- out_ready_i  in  1  downstream accepts the result.
- busy_o  out  1  flush in progress, capture pending or output held.

## Operation
- **States:** RUN and FLUSH. Reset enters RUN.
- **Stall term:** `stall = (out_valid_o & ~out_ready_i) | cap_pend`.
- **in_ready_o:** `(state==RUN) & ~flush_i & ~stall`. Forced to 0 while `rst` is high.
- **RUN:**
  - `fir_en_o = in_valid_i & in_ready_o`.
  - `fir_data_o = in_data_i`.
- **FLUSH:**
  - `fir_en_o = ~stall`.
  - `fir_data_o = 0`.
  - `flush_cnt` counts issued enables.
  - After LAT-1 zero enables, return to RUN. On that transition clear `fill_cnt` and `dec_cnt`.
- **flush_i:**
  - Sampled in RUN only; ignored in FLUSH.
  - A flush_i cycle accepts no input. The state is FLUSH from the next cycle.
- **fill_cnt:**
  - Counts enables up to LAT-1, then saturates.
  - An enable is result-bearing when `fill_cnt == LAT-1` at the time of that enable.
- **dec_cnt:**
  - Counts 0..DECIM-1, wraps, and advances only on result-bearing enables.
  - A result-bearing enable with `dec_cnt == 0` sets `cap_pend` for the next cycle. The first valid result is therefore always output.
- **Capture:**
  - In the cycle where `cap_pend` is high, load `out_data_o <= fir_result_i` and set `out_valid_o`.
  - The stall term guarantees the output register is free.
- **Output handshake:**
  - `out_valid_o` clears on `out_valid_o & out_ready_i`, unless a capture occurs in the same cycle.
  - Data is held stable while `out_valid_o & ~out_ready_i`.
- **Data path:** no arithmetic. The result is passed as-is; the FIR performs scaling and rounding.
- **Reset (any state, including mid-flush):**
  - Outputs: `in_ready_o`, `fir_en_o`, `out_valid_o`, `busy_o` = 0; `fir_data_o`, `out_data_o` = 0.
  - Internal: `cap_pend` = 0; all counters = 0.
  - Outstanding capture and flush are discarded.

## Timing
- `fir_en_o` is combinational, in the same cycle as the accepting handshake.
- Enable in cycle t: `fir_result_i` reflects it in t+1; capture at the end of t+1; `out_valid_o` high from t+2.
- Latency from accepting handshake to `out_valid_o` is 2 cycles.
- **Throughput:**
  - One sample per cycle, except the cycle after a capturing enable (`cap_pend`), where `in_ready_o` is 0.
  - With DECIM=1, one sample per 2 cycles.
- **busy_o:** `(state==FLUSH) | cap_pend | out_valid_o`, registered-state derived.

## Test plan
- **Reset:** assert `rst` 3 cycles with `in_valid_i=1`. All outputs are 0 throughout; `in_ready_o` rises in the first cycle after `rst` drops.
- **LAT=3, DECIM=1:**
  - Stimulus: impulse 16384 then zeros, `out_ready_i=1`.
  - No `out_valid_o` for the first 2 enables.
  - First `out_valid_o` exactly 2 cycles after the 3rd enable, carrying the FIR response to the impulse.
  - `in_ready_o` low every cycle after a capturing enable.
- **DECIM=4:**
  - Stimulus: 18 back-to-back valid samples.
  - Captures on enables 3, 7, 11, 15 (4 outputs).
  - `in_ready_o` is 0 in the cycles after those enables.
  - Total input beats are counted; none lost.
- **Backpressure:**
  - Stimulus: `out_ready_i=0` for 20 cycles with a continuous input.
  - At most one further capturing enable occurs after the first output.
  - Then `in_ready_o=0` and `fir_en_o=0` until `out_ready_i` rises.
  - `out_data_o` is held stable; no sample is dropped or duplicated.
- **Flush:**
  - Stimulus: after 10 samples pulse `flush_i` with `in_valid_i=1`.
  - No accept in the flush_i cycle.
  - Exactly 2 `fir_en_o` with `fir_data_o=0`, then RUN.
  - The next 2 enables are not result-bearing; the 3rd is captured.
- **Reset mid-flush:** assert `rst` after the 1st flush enable. Next cycle: RUN with all counters 0, no `out_valid_o`, and no further zero enables.
